// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer block.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_timer_state_e;

  localparam int unsigned TICK_TIMER_W = 16;

endpackage

// File: rtl/tick_timer_fsm.sv
// tick_timer control FSM: state register, stop > start > expiry priority, mode capture.
module tick_timer_fsm
  import tick_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              periodic,
  input  logic              expire,
  output tick_timer_state_e state,
  output logic              mode,
  output logic              busy,
  output logic              done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      state <= RUN;
      mode  <= periodic;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (expire && state == RUN && !mode) begin
      state <= DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// Tick-driven one-shot/periodic timer with period load handshake and expiry irq.
// Optional feature: TICK_TIMER_STICKY_IRQ_EN (irq held until irq_clr).
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned W = TICK_TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic         load_valid,
  input  logic [W-1:0] load_period,
  output logic         load_ready,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         irq,
  input  logic         irq_clr
);

  tick_timer_state_e state;
  logic              mode;
  logic [W-1:0]      period_q;
  logic [W-1:0]      p_eff;
  logic              count_en;
  logic              expire;

  tick_timer_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .expire   (expire),
    .state    (state),
    .mode     (mode),
    .busy     (busy),
    .done     (done)
  );

  assign load_ready = (state != RUN);

  // A period of zero behaves as one, so every counted tick expires.
  assign p_eff    = (period_q == '0) ? W'(1) : period_q;
  assign count_en = (state == RUN) && tick && !start && !stop;
  assign expire   = count_en && (cnt == p_eff - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '1;
    end else if (load_valid && load_ready) begin
      period_q <= load_period;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start || stop || expire) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + W'(1);
    end
  end

`ifdef TICK_TIMER_STICKY_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (expire) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= expire;
    end
  end
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Randomized and directed self-checking bench for tick_timer against a behavioural model.
module tb_tick_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_period = '0;
  logic         irq_clr = 1'b0;
  logic         load_ready;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         irq;

  int total = 0;
  int bad   = 0;

  // Reference model: timer status kept as plain integers and flags.
  bit m_running, m_expired_oneshot, m_periodic, m_irq;
  int m_period, m_ticks;

  tick_timer #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .load_valid  (load_valid),
    .load_period (load_period),
    .load_ready  (load_ready),
    .cnt         (cnt),
    .busy        (busy),
    .done        (done),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_running = 0; m_expired_oneshot = 0; m_periodic = 0; m_irq = 0;
    m_period = (1 << W) - 1; m_ticks = 0;
  endfunction

  function automatic void model_step();
    int  eff;
    bit  counted, hit;
    eff     = (m_period == 0) ? 1 : m_period;
    counted = m_running && tick && !start && !stop;
    hit     = counted && (m_ticks + 1 == eff);
    if (load_valid && !m_running) m_period = int'(load_period);
    if (stop) begin
      m_running = 0; m_expired_oneshot = 0;
    end else if (start) begin
      m_running = 1; m_expired_oneshot = 0; m_periodic = periodic;
    end else if (hit && !m_periodic) begin
      m_running = 0; m_expired_oneshot = 1;
    end
    if (start || stop || hit) m_ticks = 0;
    else if (counted)         m_ticks = m_ticks + 1;
`ifdef TICK_TIMER_STICKY_IRQ_EN
    if (hit) m_irq = 1;
    else if (irq_clr) m_irq = 0;
`else
    m_irq = hit;
`endif
  endfunction

  task automatic compare_all();
    check("cnt", 32'(cnt), 32'(m_ticks));
    check("busy", 32'(busy), 32'(m_running));
    check("done", 32'(done), 32'(m_expired_oneshot));
    check("irq", 32'(irq), 32'(m_irq));
    check("load_ready", 32'(load_ready), 32'(!m_running));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    tick = 0; start = 0; stop = 0; periodic = 0;
    load_valid = 0; load_period = '0; irq_clr = 0;
  endtask

  int pulses;

  initial begin
    model_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ready", 32'(load_ready), 1);
    rst = 0;
    cycle();

    // P=3 one-shot, load coincident with start, tick every cycle
    start = 1; load_valid = 1; load_period = 3; cycle();
    idle_inputs(); tick = 1;
    cycle(); cycle();
    check("os_pre_irq", 32'(irq), 0);
    cycle();
    check("os_irq", 32'(irq), 1);
    check("os_done", 32'(done), 1);
    check("os_busy", 32'(busy), 0);
    check("os_cnt", 32'(cnt), 0);
    tick = 0; cycle();
`ifndef TICK_TIMER_STICKY_IRQ_EN
    check("os_irq_pulse", 32'(irq), 0);
`endif
    irq_clr = 1; cycle(); irq_clr = 0;

    // P=2 periodic, tick every 4 cycles, 6 ticks
    start = 1; periodic = 1; load_valid = 1; load_period = 2; cycle();
    idle_inputs();
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick = (i % 4 == 0);
      cycle();
      if (irq) pulses++;
      check("per_busy", 32'(busy), 1);
    end
`ifndef TICK_TIMER_STICKY_IRQ_EN
    check("per_pulses", 32'(pulses), 3);
`endif

    // stop coincident with expiring tick
    tick = 1; cycle();
    irq_clr = 1; tick = 0; cycle(); irq_clr = 0;
    tick = 1; stop = 1; cycle();
    check("stop_tick_irq", 32'(irq), 0);
    check("stop_tick_busy", 32'(busy), 0);
    check("stop_tick_cnt", 32'(cnt), 0);
    idle_inputs();

    // start+stop from DONE
    start = 1; load_valid = 1; load_period = 1; cycle();
    idle_inputs(); tick = 1; cycle(); tick = 0;
    check("done_reached", 32'(done), 1);
    start = 1; stop = 1; cycle(); idle_inputs();
    check("ss_busy", 32'(busy), 0);
    check("ss_done", 32'(done), 0);
    irq_clr = 1; cycle(); irq_clr = 0;

    // load held during RUN stalls until after stop
    start = 1; load_valid = 1; load_period = 8; cycle();
    idle_inputs(); load_valid = 1; load_period = 5;
    for (int i = 0; i < 3; i++) begin
      tick = 1; cycle();
      check("run_ready", 32'(load_ready), 0);
    end
    tick = 0; stop = 1; cycle(); stop = 0;
    check("after_stop_ready", 32'(load_ready), 1);
    cycle(); load_valid = 0;
    start = 1; cycle(); start = 0; tick = 1;
    for (int i = 0; i < 5; i++) cycle();
    check("p5_expire", 32'(done), 1);
    tick = 0; irq_clr = 1; cycle(); irq_clr = 0;

    // P=0 one-shot expires on first tick
    start = 1; load_valid = 1; load_period = 0; cycle();
    idle_inputs(); tick = 1; cycle(); tick = 0;
    check("p0_irq", 32'(irq), 1);
    check("p0_done", 32'(done), 1);

    // irq_clr behaviour
    cycle(); cycle();
`ifdef TICK_TIMER_STICKY_IRQ_EN
    check("sticky_hold", 32'(irq), 1);
    irq_clr = 1; cycle(); irq_clr = 0;
    check("sticky_clr", 32'(irq), 0);
    start = 1; periodic = 1; cycle(); start = 0;
    tick = 1; irq_clr = 1; cycle(); tick = 0; irq_clr = 0;
    check("sticky_coincide", 32'(irq), 1);
    irq_clr = 1; cycle(); irq_clr = 0;
`else
    check("pulse_low", 32'(irq), 0);
    start = 1; periodic = 1; cycle(); start = 0;
    tick = 1; irq_clr = 1; cycle(); irq_clr = 0;
    check("clr_ignored", 32'(irq), 1);
    tick = 0; cycle();
`endif
    stop = 1; cycle(); stop = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick        = ($urandom_range(1, 0) == 1);
      start       = ($urandom_range(15, 0) == 0);
      stop        = ($urandom_range(31, 0) == 0);
      periodic    = $urandom_range(1, 0);
      load_valid  = ($urandom_range(3, 0) == 0);
      load_period = W'($urandom_range(6, 0));
      irq_clr     = ($urandom_range(7, 0) == 0);
      cycle();
    end
    idle_inputs();
    stop = 1; cycle(); stop = 0;

    // asynchronous reset mid-run with cnt = 7
    start = 1; load_valid = 1; load_period = 20; cycle();
    idle_inputs(); tick = 1;
    for (int i = 0; i < 7; i++) cycle();
    tick = 0;
    check("pre_rst_cnt", 32'(cnt), 7);
    #2 rst = 1;
    #1;
    check("arst_cnt", 32'(cnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_irq", 32'(irq), 0);
    check("arst_ready", 32'(load_ready), 1);
    model_reset();
    #1 rst = 0;
    tick = 1; cycle(); tick = 0;
    check("post_rst_cnt", 32'(cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
